// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - parametrised video timing and selectable RGB test-pattern generator
module video_pattern_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int POS_W     = 10,
    parameter int COLOR_W   = 8,
    parameter int BAR_W     = 80,
    parameter int CHK_SHIFT = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [2:0]         i_mode,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_hblank,
    output logic               o_vblank,
    output logic [POS_W-1:0]   o_hpos,
    output logic [POS_W-1:0]   o_vpos,
    output logic               o_visible,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b,
    output logic               o_frame_start,
    output logic [7:0]         o_frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [POS_W-1:0] H_LAST     = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_VIS      = POS_W'(H_VISIBLE);
    localparam logic [POS_W-1:0] V_VIS      = POS_W'(V_VISIBLE);
    localparam logic [POS_W-1:0] H_VIS_LAST = POS_W'(H_VISIBLE - 1);
    localparam logic [POS_W-1:0] V_VIS_LAST = POS_W'(V_VISIBLE - 1);
    localparam logic [POS_W-1:0] HS_FIRST   = POS_W'(H_VISIBLE + H_FRONT);
    localparam logic [POS_W-1:0] HS_LAST    = POS_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_FIRST   = POS_W'(V_VISIBLE + V_FRONT);
    localparam logic [POS_W-1:0] VS_LAST    = POS_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

    logic [POS_W-1:0]  h;
    logic [POS_W-1:0]  v;
    logic [BAR_CW-1:0] in_bar;
    logic [2:0]        bar;
    logic [2:0]        mode;
    logic [7:0]        frame_count;

    // Bar index to RGB on/off mask: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [2:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 3'b111;
            3'd1:    palette = 3'b110;
            3'd2:    palette = 3'b011;
            3'd3:    palette = 3'b010;
            3'd4:    palette = 3'b101;
            3'd5:    palette = 3'b100;
            3'd6:    palette = 3'b001;
            default: palette = 3'b000;
        endcase
    endfunction

    // Raster counters, bar tracking and frame-boundary mode/frame-count update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h           <= '0;
            v           <= '0;
            in_bar      <= '0;
            bar         <= '0;
            mode        <= '0;
            frame_count <= '0;
        end else if (h == H_LAST) begin
            h      <= '0;
            in_bar <= '0;
            bar    <= '0;
            if (v == V_LAST) begin
                v           <= '0;
                mode        <= i_mode;
                frame_count <= frame_count + 8'd1;
            end else begin
                v <= v + 1'b1;
            end
        end else begin
            h <= h + 1'b1;
            if (h < H_VIS) begin
                if (in_bar == BAR_LAST) begin
                    in_bar <= '0;
                    if (bar != 3'd7) begin
                        bar <= bar + 3'd1;
                    end
                end else begin
                    in_bar <= in_bar + 1'b1;
                end
            end
        end
    end

    logic hs_active;
    logic vs_active;
    logic hblank;
    logic vblank;
    logic visible;

    // Sync/blank decode of the current counter position
    always_comb begin
        hs_active = (h >= HS_FIRST) && (h <= HS_LAST);
        vs_active = (v >= VS_FIRST) && (v <= VS_LAST);
        hblank    = (h >= H_VIS);
        vblank    = (v >= V_VIS);
        visible   = !hblank && !vblank;
    end

    logic [2:0]         bar_idx;
    logic [2:0]         bar_rgb;
    logic               mono;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;

    // Pattern colour for the current position; scrolling bars offset the index by frame_count/4
    always_comb begin
        bar_idx = (mode == 3'd4) ? bar + frame_count[4:2] : bar;
        bar_rgb = palette(bar_idx);
        mono    = 1'b0;
        pix_r   = '0;
        pix_g   = '0;
        pix_b   = '0;
        case (mode)
            3'd0, 3'd4: begin
                pix_r = {COLOR_W{bar_rgb[2]}};
                pix_g = {COLOR_W{bar_rgb[1]}};
                pix_b = {COLOR_W{bar_rgb[0]}};
            end
            3'd1: begin
                mono  = h[CHK_SHIFT] ^ v[CHK_SHIFT];
                pix_r = {COLOR_W{mono}};
                pix_g = {COLOR_W{mono}};
                pix_b = {COLOR_W{mono}};
            end
            3'd2: begin
                mono  = (h[4:0] == 5'd0) || (v[4:0] == 5'd0) ||
                        (h == H_VIS_LAST) || (v == V_VIS_LAST);
                pix_r = {COLOR_W{mono}};
                pix_g = {COLOR_W{mono}};
                pix_b = {COLOR_W{mono}};
            end
            3'd3: begin
                pix_r = h[COLOR_W+1:2];
                pix_g = h[COLOR_W+1:2];
                pix_b = h[COLOR_W+1:2];
            end
            default: begin
                mono = 1'b0;
            end
        endcase
    end

    // Single output stage: every output registered from the same counter snapshot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_hblank      <= 1'b0;
            o_vblank      <= 1'b0;
            o_hpos        <= '0;
            o_vpos        <= '0;
            o_visible     <= 1'b0;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
            o_frame_start <= 1'b0;
            o_frame_count <= '0;
        end else begin
            o_hsync       <= hs_active ? HSYNC_POL : ~HSYNC_POL;
            o_vsync       <= vs_active ? VSYNC_POL : ~VSYNC_POL;
            o_hblank      <= hblank;
            o_vblank      <= vblank;
            o_hpos        <= h;
            o_vpos        <= v;
            o_visible     <= visible;
            o_r           <= visible ? pix_r : '0;
            o_g           <= visible ? pix_g : '0;
            o_b           <= visible ? pix_b : '0;
            o_frame_start <= (h == '0) && (v == '0);
            o_frame_count <= frame_count;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - scoreboard bench for video_pattern_gen on a reduced video mode
module tb_video_pattern_gen;

    localparam int HV = 18, HF = 2, HS = 3, HB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 5, VF = 1, VS = 1, VB = 1;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;
    localparam int PW = 5, CW = 3, BW = 2, CHK = 1;
    localparam logic [CW-1:0] F = '1;
    localparam logic [CW-1:0] Z = '0;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
        logic          vis;
        logic          fs;
        logic [PW-1:0] hpos;
        logic [PW-1:0] vpos;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
        logic [7:0]    fc;
    } pix_t;

    logic          clk;
    logic          rst_n;
    logic [2:0]    i_mode;
    logic          hsync, vsync, hblank, vblank, visible, fstart;
    logic [PW-1:0] hpos, vpos;
    logic [CW-1:0] r, g, b;
    logic [7:0]    fcount;
    pix_t          act;

    video_pattern_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HSP), .VSYNC_POL(VSP), .POS_W(PW), .COLOR_W(CW),
        .BAR_W(BW), .CHK_SHIFT(CHK)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(i_mode),
        .o_hsync(hsync), .o_vsync(vsync), .o_hblank(hblank), .o_vblank(vblank),
        .o_hpos(hpos), .o_vpos(vpos), .o_visible(visible),
        .o_r(r), .o_g(g), .o_b(b),
        .o_frame_start(fstart), .o_frame_count(fcount)
    );

    assign act = {hsync, vsync, hblank, vblank, visible, fstart, hpos, vpos, r, g, b, fcount};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int mism = 0;
    bit have_bad = 1'b0;
    pix_t bad_a, bad_e;

    function automatic logic [3*CW-1:0] pal_rgb(input int i);
        case (i)
            0:       pal_rgb = {F, F, F};
            1:       pal_rgb = {F, F, Z};
            2:       pal_rgb = {Z, F, F};
            3:       pal_rgb = {Z, F, Z};
            4:       pal_rgb = {F, Z, F};
            5:       pal_rgb = {F, Z, Z};
            6:       pal_rgb = {Z, Z, F};
            default: pal_rgb = {Z, Z, Z};
        endcase
    endfunction

    function automatic pix_t model_pix(input int h, input int v, input int mode, input int fc);
        pix_t p;
        logic [3*CW-1:0] rgb;
        int bi;
        p.hs   = (h >= HV + HF && h < HV + HF + HS) ? HSP : ~HSP;
        p.vs   = (v >= VV + VF && v < VV + VF + VS) ? VSP : ~VSP;
        p.hb   = (h >= HV);
        p.vb   = (v >= VV);
        p.vis  = !p.hb && !p.vb;
        p.fs   = (h == 0 && v == 0);
        p.hpos = PW'(h);
        p.vpos = PW'(v);
        p.fc   = 8'(fc);
        bi     = (h / BW > 7) ? 7 : h / BW;
        rgb    = '0;
        if (p.vis) begin
            case (mode)
                0: rgb = pal_rgb(bi);
                1: if ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) rgb = {F, F, F};
                2: if (h % 32 == 0 || v % 32 == 0 || h == HV - 1 || v == VV - 1) rgb = {F, F, F};
                3: rgb = {3{CW'((h >> 2) % (1 << CW))}};
                4: rgb = pal_rgb((bi + fc / 4) % 8);
                default: rgb = '0;
            endcase
        end
        {p.r, p.g, p.b} = rgb;
        return p;
    endfunction

    int mh = 0, mv = 0, mmode = 0, mfc = 0;
    pix_t exp_q[$];

    // Reference raster: one expected pixel is queued per active clock edge
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mh = 0; mv = 0; mmode = 0; mfc = 0;
                exp_q.delete();
            end else begin
                exp_q.push_back(model_pix(mh, mv, mmode, mfc));
                if (mh == HT - 1) begin
                    mh = 0;
                    if (mv == VT - 1) begin
                        mv = 0;
                        mmode = int'(i_mode);
                        mfc = (mfc + 1) % 256;
                    end else begin
                        mv++;
                    end
                end else begin
                    mh++;
                end
            end
        end
    end

    task automatic next_pixel(output pix_t e, output pix_t a);
        @(negedge clk);
        a = act;
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        if (a !== e) begin
            mism++;
            if (!have_bad) begin
                have_bad = 1'b1;
                bad_a = a;
                bad_e = e;
            end
        end
    endtask

    task automatic wait_pos(input int h, input int v, output pix_t e, output pix_t a);
        int n = 0;
        do begin
            next_pixel(e, a);
            n++;
        end while (!(a.hpos === PW'(h) && a.vpos === PW'(v)) && n < 2 * FR + 2);
        if (!(a.hpos === PW'(h) && a.vpos === PW'(v))) begin
            fails++;
            $display("FAIL wait_pos: stopped at hpos=%0d vpos=%0d, required hpos=%0d vpos=%0d", a.hpos, a.vpos, h, v);
            $fatal(1, "position never reached");
        end
    endtask

    task automatic clear_model_tally();
        mism = 0;
        have_bad = 1'b0;
    endtask

    task automatic test_reset();
        pix_t e, a, r0;
        r0 = '0;
        r0.hs = 1'b1;
        r0.vs = 1'b0;
        rst_n = 1'b0;
        i_mode = 3'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (act !== r0) begin fails++; $display("FAIL reset_values: actual %h required %h", act, r0); end
        rst_n = 1'b1;
        clear_model_tally();
        next_pixel(e, a);
        tests++;
        if ({a.hpos, a.vpos} !== '0) begin fails++; $display("FAIL first_pos: actual %0d,%0d required 0,0", a.hpos, a.vpos); end
        tests++;
        if (a.fs !== 1'b1) begin fails++; $display("FAIL first_frame_start: actual %b required 1", a.fs); end
        tests++;
        if (a.vis !== 1'b1) begin fails++; $display("FAIL first_visible: actual %b required 1", a.vis); end
        tests++;
        if ({a.r, a.g, a.b} !== 9'o777) begin fails++; $display("FAIL first_rgb: actual %o required 777", {a.r, a.g, a.b}); end
    endtask

    task automatic test_line_timing();
        pix_t e, a;
        int hs_cnt = 0, hs_first = -1, hb_first = -1;
        logic [3*CW-1:0] rgb_at [HT];
        logic vis_at_hv = 1'b1;
        for (int i = 1; i <= HT; i++) begin
            next_pixel(e, a);
            if (a.hs == HSP) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(a.hpos);
            end
            if (a.hb && hb_first < 0) hb_first = int'(a.hpos);
            if (i < HT) rgb_at[i] = {a.r, a.g, a.b};
            if (i == HV) vis_at_hv = a.vis;
        end
        tests++;
        if (hs_cnt !== 3) begin fails++; $display("FAIL hsync_width: actual %0d required 3", hs_cnt); end
        tests++;
        if (hs_first !== 20) begin fails++; $display("FAIL hsync_start: actual %0d required 20", hs_first); end
        tests++;
        if (hb_first !== 18) begin fails++; $display("FAIL hblank_start: actual %0d required 18", hb_first); end
        tests++;
        if ({a.hpos, a.vpos} !== {5'd0, 5'd1}) begin fails++; $display("FAIL line_wrap: actual %0d,%0d required 0,1", a.hpos, a.vpos); end
        tests++;
        if (rgb_at[1] !== 9'o777) begin fails++; $display("FAIL bar0_last: actual %o required 777", rgb_at[1]); end
        tests++;
        if (rgb_at[2] !== 9'o770) begin fails++; $display("FAIL bar1_first: actual %o required 770", rgb_at[2]); end
        tests++;
        if (rgb_at[13] !== 9'o007) begin fails++; $display("FAIL bar6_blue: actual %o required 007", rgb_at[13]); end
        tests++;
        if (rgb_at[14] !== 9'o000) begin fails++; $display("FAIL bar7_black: actual %o required 000", rgb_at[14]); end
        tests++;
        if (rgb_at[17] !== 9'o000) begin fails++; $display("FAIL bar_saturate: actual %o required 000", rgb_at[17]); end
        tests++;
        if (rgb_at[18] !== 9'o000 || vis_at_hv !== 1'b0) begin
            fails++; $display("FAIL blank_rgb: actual %o vis %b required 000 vis 0", rgb_at[18], vis_at_hv);
        end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL line_model: %0d pixels differ, first actual %h required %h", mism, bad_a, bad_e); end
    endtask

    task automatic test_frame_timing();
        pix_t e, a;
        int n = 0, fs_cnt = 0, vs_cnt = 0, vs_first = -1;
        clear_model_tally();
        wait_pos(0, 0, e, a);
        tests++;
        if (a.fc !== 8'd1) begin fails++; $display("FAIL frame_count_1: actual %0d required 1", a.fc); end
        do begin
            next_pixel(e, a);
            n++;
            if (a.fs) fs_cnt++;
            if (a.vs == VSP) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = int'(a.vpos);
            end
        end while (a.fs !== 1'b1 && n < 2 * FR);
        tests++;
        if (n !== FR) begin fails++; $display("FAIL frame_period: actual %0d required %0d", n, FR); end
        tests++;
        if (fs_cnt !== 1) begin fails++; $display("FAIL frame_start_count: actual %0d required 1", fs_cnt); end
        tests++;
        if (vs_cnt !== HT || vs_first !== 6) begin
            fails++; $display("FAIL vsync_lines: actual %0d clocks from line %0d required %0d from 6", vs_cnt, vs_first, HT);
        end
        tests++;
        if (a.fc !== 8'd2) begin fails++; $display("FAIL frame_count_2: actual %0d required 2", a.fc); end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL frame_model: %0d pixels differ, first actual %h required %h", mism, bad_a, bad_e); end
    endtask

    task automatic test_mode_switch();
        pix_t e, a;
        int lit = 0;
        clear_model_tally();
        wait_pos(0, 2, e, a);
        i_mode = 3'd1;
        wait_pos(2, 3, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o770) begin fails++; $display("FAIL bars_persist: actual %o required 770", {a.r, a.g, a.b}); end
        wait_pos(2, 0, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o777) begin fails++; $display("FAIL checker_2_0: actual %o required 777", {a.r, a.g, a.b}); end
        wait_pos(2, 2, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o000) begin fails++; $display("FAIL checker_2_2: actual %o required 000", {a.r, a.g, a.b}); end
        i_mode = 3'd5;
        wait_pos(0, 0, e, a);
        if ({a.r, a.g, a.b} !== '0) lit++;
        for (int i = 1; i < FR; i++) begin
            next_pixel(e, a);
            if ({a.r, a.g, a.b} !== '0) lit++;
        end
        tests++;
        if (lit !== 0) begin fails++; $display("FAIL mode5_black: actual %0d lit pixels required 0", lit); end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL switch_model: %0d pixels differ, first actual %h required %h", mism, bad_a, bad_e); end
    endtask

    task automatic test_wrap_change();
        pix_t e, a;
        clear_model_tally();
        wait_pos(24, 7, e, a);
        i_mode = 3'd2;
        next_pixel(e, a);
        next_pixel(e, a);
        i_mode = 3'd3;
        tests++;
        if ({a.hpos, a.vpos, a.r, a.g, a.b} !== {5'd0, 5'd0, 9'o777}) begin
            fails++; $display("FAIL wrap_mode: actual %0d,%0d rgb %o required 0,0 rgb 777", a.hpos, a.vpos, {a.r, a.g, a.b});
        end
        wait_pos(0, 1, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o777) begin fails++; $display("FAIL grid_col0: actual %o required 777", {a.r, a.g, a.b}); end
        wait_pos(1, 1, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o000) begin fails++; $display("FAIL grid_inner: actual %o required 000", {a.r, a.g, a.b}); end
        wait_pos(17, 1, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o777) begin fails++; $display("FAIL grid_last_col: actual %o required 777", {a.r, a.g, a.b}); end
        wait_pos(5, 4, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o777) begin fails++; $display("FAIL grid_last_row: actual %o required 777", {a.r, a.g, a.b}); end
        wait_pos(9, 0, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o222) begin fails++; $display("FAIL grey_9: actual %o required 222", {a.r, a.g, a.b}); end
        wait_pos(17, 3, e, a);
        tests++;
        if ({a.r, a.g, a.b} !== 9'o444) begin fails++; $display("FAIL grey_17: actual %o required 444", {a.r, a.g, a.b}); end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL wrap_model: %0d pixels differ, first actual %h required %h", mism, bad_a, bad_e); end
    endtask

    task automatic test_scroll();
        pix_t e, a;
        logic [3*CW-1:0] want0, want2;
        @(negedge clk);
        rst_n = 1'b0;
        i_mode = 3'd4;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model_tally();
        next_pixel(e, a);
        for (int f = 0; f < 8; f++) begin
            if (f > 0) wait_pos(0, 0, e, a);
            want0 = (f < 4) ? 9'o777 : 9'o770;
            want2 = (f < 4) ? 9'o770 : 9'o077;
            tests++;
            if (a.fc !== 8'(f)) begin fails++; $display("FAIL scroll_fc: actual %0d required %0d", a.fc, f); end
            tests++;
            if ({a.r, a.g, a.b} !== want0) begin fails++; $display("FAIL scroll_h0 frame %0d: actual %o required %o", f, {a.r, a.g, a.b}, want0); end
            wait_pos(2, 0, e, a);
            tests++;
            if ({a.r, a.g, a.b} !== want2) begin fails++; $display("FAIL scroll_h2 frame %0d: actual %o required %o", f, {a.r, a.g, a.b}, want2); end
        end
    endtask

    task automatic test_frame_count_wrap();
        pix_t e, a;
        int frames = 0;
        int last_fc = 7;
        do begin
            wait_pos(0, 0, e, a);
            frames++;
            if (a.fc !== 8'd0) last_fc = int'(a.fc);
        end while (a.fc !== 8'd0 && frames < 300);
        tests++;
        if (frames !== 249 || last_fc !== 255) begin
            fails++; $display("FAIL fc_wrap: actual %0d frames last %0d required 249 frames last 255", frames, last_fc);
        end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL scroll_model: %0d pixels differ, first actual %h required %h", mism, bad_a, bad_e); end
    endtask

    task automatic test_reset_midframe();
        pix_t e, a, r0;
        r0 = '0;
        r0.hs = 1'b1;
        r0.vs = 1'b0;
        wait_pos(0, 3, e, a);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (act !== r0) begin fails++; $display("FAIL async_reset: actual %h required %h", act, r0); end
        @(negedge clk);
        tests++;
        if (act !== r0) begin fails++; $display("FAIL reset_hold: actual %h required %h", act, r0); end
        rst_n = 1'b1;
        clear_model_tally();
        next_pixel(e, a);
        tests++;
        if ({a.hpos, a.vpos, a.fs, a.fc} !== {5'd0, 5'd0, 1'b1, 8'd0}) begin
            fails++; $display("FAIL post_reset_first: actual %0d,%0d fs %b fc %0d required 0,0 fs 1 fc 0", a.hpos, a.vpos, a.fs, a.fc);
        end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL post_reset_model: %0d pixels differ, first actual %h required %h", mism, bad_a, bad_e); end
    endtask

    initial begin
        rst_n = 1'b0;
        i_mode = 3'd0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_mode_switch();
        test_wrap_change();
        test_scroll();
        test_frame_count_wrap();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
